// File: rtl/sistema_hex_pkg.sv
// Shared constants for the hex display controller: register map, CTRL
// field positions, blink divider default and the 7-segment lookup table.
package sistema_hex_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_RAW0   = 3'd4;
    localparam logic [2:0] ADDR_RAW1   = 3'd5;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_RAW_BIT   = 1;
    localparam int CTRL_DEN_LSB   = 8;
    localparam int CTRL_BLINK_LSB = 16;

    localparam int unsigned BLINK_DIV_DEFAULT = 25000000;

    // Active-high g..a patterns, entry n at bits [7n+6:7n].
    localparam logic [16*7-1:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sistema_hex_seg_decode.sv
// Combinational nibble to active-high 7-segment pattern (g..a, msb..lsb).
module sistema_hex_seg_decode
    import sistema_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[7*int'(nibble) +: 7];

endmodule

// File: rtl/sistema_hex_display_ctrl.sv
// Avalon-MM slave driving up to eight 7-segment digits with hex decode,
// raw segment mode, per-digit enable and per-digit blinking.
module sistema_hex_display_ctrl
    import sistema_hex_pkg::*;
#(
    parameter int          NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = BLINK_DIV_DEFAULT,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam logic [7:0]  DIG_MASK   = 8'((64'd1 << NUM_DIGITS) - 64'd1);
    localparam logic [31:0] DATA_MASK  = 32'((64'd1 << (4*NUM_DIGITS)) - 64'd1);
    localparam logic [55:0] RAW_MASK   = 56'((64'd1 << (7*NUM_DIGITS)) - 64'd1);
    // The default divider exceeds 24 bits; it wraps to the register width.
    localparam logic [23:0] PERIOD_RST = 24'(BLINK_DIV);

    logic [31:0] data_q;
    logic [55:0] raw_q;
    logic        en_q;
    logic        raw_mode_q;
    logic [7:0]  den_q;
    logic [7:0]  blink_q;
    logic [23:0] period_q;
    logic [23:0] cnt_q;
    logic        phase_q;
    logic [7*NUM_DIGITS-1:0] seg_pat;

    // Bus protocol: a write is taken on any rising edge where chipselect=1
    // and write_n=0; reads have no strobe and readdata follows address
    // combinationally with zero wait states.
    logic wr;
    assign wr = chipselect & ~write_n;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [6:0] hex_seg;
        logic       blank;

        sistema_hex_seg_decode u_dec (
            .nibble (data_q[4*k +: 4]),
            .seg    (hex_seg)
        );

        assign blank = ~en_q | ~den_q[k] | (blink_q[k] & phase_q);
        assign seg_pat[7*k +: 7] = blank      ? 7'h00 :
                                   raw_mode_q ? raw_q[7*k +: 7] : hex_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            raw_q      <= '0;
            en_q       <= 1'b1;
            raw_mode_q <= 1'b0;
            den_q      <= DIG_MASK;
            blink_q    <= '0;
            period_q   <= PERIOD_RST;
            cnt_q      <= PERIOD_RST;
            phase_q    <= 1'b0;
            out_port   <= ACTIVE_LOW ? '1 : '0;
        end else begin
            out_port <= ACTIVE_LOW ? ~seg_pat : seg_pat;

            if (wr) begin
                case (address)
                    ADDR_DATA: data_q <= writedata & DATA_MASK;
                    ADDR_CTRL: begin
                        en_q       <= writedata[CTRL_EN_BIT];
                        raw_mode_q <= writedata[CTRL_RAW_BIT];
                        den_q      <= writedata[CTRL_DEN_LSB +: 8] & DIG_MASK;
                        blink_q    <= writedata[CTRL_BLINK_LSB +: 8] & DIG_MASK;
                    end
                    ADDR_RAW0: raw_q[27:0]  <= writedata[27:0] & RAW_MASK[27:0];
                    ADDR_RAW1: raw_q[55:28] <= writedata[27:0] & RAW_MASK[55:28];
                    default: ;
                endcase
            end

            // A period write restarts the blink timer even on terminal count.
            if (wr && address == ADDR_PERIOD) begin
                period_q <= writedata[23:0];
                cnt_q    <= writedata[23:0];
                phase_q  <= 1'b0;
            end else if (period_q == 24'd0) begin
                cnt_q   <= 24'd0;
                phase_q <= 1'b0;
            end else if (cnt_q == 24'd0) begin
                cnt_q   <= period_q;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q - 24'd1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = data_q;
            ADDR_CTRL: begin
                readdata[CTRL_EN_BIT]          = en_q;
                readdata[CTRL_RAW_BIT]         = raw_mode_q;
                readdata[CTRL_DEN_LSB +: 8]    = den_q;
                readdata[CTRL_BLINK_LSB +: 8]  = blink_q;
            end
            ADDR_STATUS: readdata = {cnt_q, 7'd0, phase_q};
            ADDR_PERIOD: readdata = {8'd0, period_q};
            ADDR_RAW0:   readdata = {4'd0, raw_q[27:0]};
            ADDR_RAW1:   readdata = {4'd0, raw_q[55:28]};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sistema_hex_display_ctrl.sv
// Self-checking bench: directed register/display scenarios followed by
// random bus traffic, compared against a time-based behavioural model.
module tb_sistema_hex_display_ctrl;

    localparam int          ND  = 6;
    localparam int unsigned DIV = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7*ND-1:0] out_port;

    int total = 0;
    int bad   = 0;

    sistema_hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (DIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  m_nib [8];
    logic [6:0]  m_raw [8];
    bit          m_en, m_rawmode;
    bit   [7:0]  m_den, m_blink;
    int unsigned m_period;
    int unsigned m_t;          // clocks since the blink timer was last (re)loaded
    logic [7*ND-1:0] m_out;
    logic [7*ND-1:0] exp_q [$];
    localparam bit [7:0] M_DMASK = 8'((1 << ND) - 1);

    function automatic int unsigned m_cnt();
        if (m_period == 0) return 0;
        return m_period - (m_t % (m_period + 1));
    endfunction

    function automatic bit m_phase();
        if (m_period == 0) return 1'b0;
        return ((m_t / (m_period + 1)) % 2) == 1;
    endfunction

    function automatic logic [7*ND-1:0] model_out();
        logic [7*ND-1:0] r;
        logic [6:0] p;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            if (!m_en || !m_den[k] || (m_blink[k] && m_phase())) p = 7'h00;
            else if (m_rawmode) p = m_raw[k];
            else p = hex_ref[m_nib[k]];
            r[7*k +: 7] = ~p;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        logic [23:0] c;
        r = '0;
        case (a)
            3'd0: for (int k = 0; k < ND; k++) r[4*k +: 4] = m_nib[k];
            3'd1: begin
                r[0] = m_en; r[1] = m_rawmode; r[15:8] = m_den; r[23:16] = m_blink;
            end
            3'd2: begin
                c = 24'(m_cnt());
                r = {c, 7'd0, m_phase()};
            end
            3'd3: r[23:0] = 24'(m_period);
            3'd4: for (int k = 0; k < 4; k++) if (k < ND) r[7*k +: 7] = m_raw[k];
            3'd5: for (int k = 4; k < 8; k++) if (k < ND) r[7*(k-4) +: 7] = m_raw[k];
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_nib[k] = '0;
            m_raw[k] = '0;
        end
        m_en = 1'b1; m_rawmode = 1'b0; m_den = M_DMASK; m_blink = '0;
        m_period = DIV; m_t = 0;
    endtask

    task automatic model_step(input bit rst, input bit cs, input bit wn,
                              input logic [2:0] a, input logic [31:0] wd);
        if (rst) begin
            model_reset();
            m_out = '1;
            return;
        end
        m_out = model_out();
        if (m_period != 0) m_t++;
        if (cs && !wn) begin
            case (a)
                3'd0: for (int k = 0; k < ND; k++) m_nib[k] = wd[4*k +: 4];
                3'd1: begin
                    m_en = wd[0]; m_rawmode = wd[1];
                    m_den = wd[15:8] & M_DMASK; m_blink = wd[23:16] & M_DMASK;
                end
                3'd3: begin m_period = wd[23:0]; m_t = 0; end
                3'd4: for (int k = 0; k < 4; k++) if (k < ND) m_raw[k] = wd[7*k +: 7];
                3'd5: for (int k = 4; k < 8; k++) if (k < ND) m_raw[k] = wd[7*(k-4) +: 7];
                default: ;
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input bit rst, input bit cs, input bit wn,
                        input logic [2:0] a, input logic [31:0] wd);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
        @(posedge clk);
        model_step(rst, cs, wn, a, wd);
        exp_q.push_back(m_out);
        @(negedge clk);
        check("out_port", out_port, exp_q.pop_front());
        check("readdata", readdata, model_read(a));
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] wd);
        tick(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic bus_rd(input logic [2:0] a);
        tick(1'b0, 1'b1, 1'b1, a, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7*ND-1:0] dec_exp;
        logic [31:0] wd;
        bit rst, cs, wn;
        logic [2:0] a;

        tick(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        tick(1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
        check("rst_blank", out_port, {(7*ND){1'b1}});
        bus_rd(3'd1);
        check("rst_digits", out_port, {ND{7'h40}});
        check("rst_ctrl", readdata, 32'h0000_3F01);

        bus_wr(3'd0, 32'h00A5_1F30);
        bus_rd(3'd0);
        dec_exp = ~{7'h77, 7'h6D, 7'h06, 7'h71, 7'h4F, 7'h3F};
        check("dec_out", out_port, dec_exp);
        check("dec_read", readdata, 32'h00A5_1F30);

        bus_wr(3'd1, 32'h0000_3F03);
        bus_wr(3'd4, 32'h0000_007F);
        bus_rd(3'd4);
        check("raw_d0", out_port[6:0], 7'h00);
        check("raw_d123", out_port[27:7], {3{7'h7F}});

        bus_wr(3'd1, 32'h0001_3F01);
        bus_wr(3'd3, 32'd3);
        for (int i = 0; i < 4; i++) bus_rd(3'd2);
        check("blink_status", readdata, 32'h0000_0301);
        bus_rd(3'd2);
        check("blink_blank", out_port[6:0], 7'h7F);
        for (int i = 0; i < 12; i++) bus_rd(3'd2);

        bus_wr(3'd3, 32'd3);
        for (int i = 0; i < 3; i++) bus_rd(3'd2);
        bus_wr(3'd3, 32'd5);
        bus_rd(3'd2);
        check("collide", readdata, 32'h0000_0400);

        bus_wr(3'd3, 32'd0);
        for (int i = 0; i < 5; i++) bus_rd(3'd2);
        check("period0", readdata, 32'h0000_0000);

        bus_wr(3'd6, $urandom);
        bus_wr(3'd7, $urandom);
        bus_rd(3'd6);
        check("rd6", readdata, 32'd0);
        bus_rd(3'd7);
        check("rd7", readdata, 32'd0);
        bus_wr(3'd0, 32'hFFA5_1F30);
        bus_rd(3'd0);
        check("data_hi", readdata, 32'h00A5_1F30);
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1);
        check("ctrl_mask", readdata, 32'h003F_3F03);

        bus_wr(3'd1, 32'h0001_3F01);
        bus_wr(3'd3, 32'd2);
        for (int i = 0; i < 3; i++) bus_rd(3'd2);
        tick(1'b1, 1'b1, 1'b0, 3'd1, 32'd0);
        bus_rd(3'd1);
        check("rst_ctrl2", readdata, 32'h0000_3F01);
        bus_rd(3'd2);
        check("rst_status", readdata, 32'h0000_3000);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 1) == 1);
            a   = 3'($urandom_range(0, 7));
            wd  = $urandom;
            if (a == 3'd3) wd = (wd & 32'hFF00_0000) | $urandom_range(0, 7);
            tick(rst, cs, wn, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sistema_hex_display_ctrl.md
SISTEMA_HEX_DISPLAY_CTRL -- requirements
Module: sistema_hex_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digits (legal 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, reset value of BLINK_PERIOD (24-bit, clocks per half-period).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 = segment lit when driven 0.
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have address  input  3  Avalon-MM word address.
REQ-007 SHALL have chipselect  input  1  slave select.
REQ-008 SHALL have write_n  input  1  active-low write strobe.
REQ-009 SHALL have writedata  input  32  write data.
REQ-010 SHALL have readdata  output  32  combinational read data, zero-wait-state.
REQ-011 SHALL have out_port  output  7*NUM_DIGITS  segment drive; digit k at bits [7k+6:7k], bit order g..a (msb..lsb).

Function
REQ-012 SHALL accept a write when chipselect=1 and write_n=0; register updates at that clk edge.
REQ-013 SHALL map: 0 DATA (4 bits/digit, digit k at [4k+3:4k]); 1 CTRL; 2 STATUS (read-only); 3 BLINK_PERIOD [23:0]; 4 RAW0 (digits 0-3, 7 bits each at [7k+6:7k]); 5 RAW1 (digits 4-7, same packing); 6-7 unmapped.
REQ-014 SHALL define CTRL: bit0 EN, bit1 RAW_MODE, [15:8] DIGIT_EN mask, [23:16] BLINK mask.
REQ-015 SHALL define STATUS: bit0 blink phase, [31:8] current blink counter.
REQ-016 SHALL return 0 for unmapped addresses, unused bits, and bits of digits >= NUM_DIGITS; writes to those SHALL be ignored.
REQ-017 SHALL derive digit k's pattern (active-high): blank if EN=0, DIGIT_EN[k]=0, or (BLINK[k]=1 and phase=1); else RAW pattern if RAW_MODE=1; else hex decode of DATA nibble.
REQ-018 SHALL use hex decode 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-019 SHALL register out_port; it SHALL be inverted when ACTIVE_LOW=1; a write at edge n SHALL be visible on out_port at edge n+1.
REQ-020 SHALL run a 24-bit down-counter: at 0, toggle phase and reload BLINK_PERIOD; else decrement.
REQ-021 SHALL hold counter and phase at 0 while BLINK_PERIOD=0 (blink disabled).
REQ-022 SHALL, on a BLINK_PERIOD write, load the counter with the new value and clear phase; this SHALL take priority over a same-cycle terminal count.
REQ-023 SHALL keep the counter running regardless of EN and BLINK mask.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set DATA=0, RAW0=RAW1=0, CTRL={BLINK=0, DIGIT_EN=all existing digits, RAW_MODE=0, EN=1}, BLINK_PERIOD=BLINK_DIV, counter=BLINK_DIV, phase=0.
REQ-025 SHALL drive out_port all-blank (all 1s if ACTIVE_LOW) during reset; first post-reset edge shows "0" on every digit.
REQ-026 SHALL let reset override any same-cycle write.

Structure
REQ-027 SHALL place address constants, CTRL bit positions, BLINK_DIV default and the hex segment table in shared package sistema_hex_pkg.
REQ-028 SHALL instantiate sub-module sistema_hex_seg_decode (4-bit in, 7-bit active-high out, combinational) once per digit.

Verification
REQ-029 SHALL cover reset: after reset, NUM_DIGITS=6, ACTIVE_LOW=1 -> out_port each digit 7'h40; CTRL reads 0x00003F01.
REQ-030 SHALL cover decode: write DATA=0x00A5_1F30 -> next edge digits 0..5 = ~3F,~4F,~71,~06,~6D,~77; DATA reads 0x00A51F30.
REQ-031 SHALL cover raw mode: CTRL=0x00003F03, RAW0=0x0000007F -> digit 0 = 7'h00, digits 1-3 = 7'h7F.
REQ-032 SHALL cover blink: BLINK_PERIOD=3, CTRL BLINK=0x01 -> digit 0 blank for 4 clocks, lit for 4, repeating; STATUS bit0 tracks.
REQ-033 SHALL cover collision: BLINK_PERIOD write on terminal-count cycle -> counter=new value, phase=0; BLINK_PERIOD=0 -> phase stays 0.
REQ-034 SHALL cover edge access: write to addresses 6/7 and DATA bits [31:24] -> no state change; reads return 0; reset asserted mid-blink -> REQ-024 values next edge.
